// File: rtl/tl_conflict_monitor.sv
// Lamp-bus safety monitor: checks sampled TL1..TL4 against intersection rules, blanks lamps to RED and latches a fault code.
// Define TLM_WATCHDOG_EN to compile in the stuck-phase watchdog (fault code 6).
module tl_conflict_monitor #(
  parameter int unsigned RED_MIN    = 3,
  parameter int unsigned GREEN_MIN  = 10,
  parameter int unsigned WATCHDOG   = 63,
  parameter int unsigned FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] TL1,
  input  logic [1:0] TL2,
  input  logic [1:0] TL3,
  input  logic [1:0] TL4,
  input  logic       fault_clear,
  output logic [1:0] LAMP1,
  output logic [1:0] LAMP2,
  output logic [1:0] LAMP3,
  output logic [1:0] LAMP4,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [7:0] RED_MIN_L   = 8'(RED_MIN);
  localparam logic [7:0] GREEN_MIN_L = 8'(GREEN_MIN);
  localparam logic [7:0] FLASH_LAST  = 8'(FLASH_HALF - 1);

  typedef enum logic [2:0] {ST_UNARMED, ST_G13, ST_G24, ST_AR, ST_FAULT} state_e;
  typedef enum logic [1:0] {CL_AR, CL_G13, CL_G24, CL_ILL} cls_e;
  typedef enum logic [1:0] {LG_NONE, LG_13, LG_24} last_e;

  state_e     state_q, state_d;
  last_e      last_green_q, last_green_d;
  logic [7:0] tl_q, tl_d;
  logic [7:0] red_cnt_q, red_cnt_d;
  logic [7:0] green_cnt_q, green_cnt_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       exempt_q, exempt_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic       flash_q, flash_d;

  logic [1:0] tl1, tl2, tl3, tl4;
  cls_e       cls;
  logic       same_cls, enters_g13, enters_g24, green_end, tracking;
  logic       v1, v2, v3, v4, v5, v6;
  logic [2:0] code_now;
  logic       viol, arm, blank;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

  assign tl1 = tl_q[7:6];
  assign tl2 = tl_q[5:4];
  assign tl3 = tl_q[3:2];
  assign tl4 = tl_q[1:0];

  always_comb begin
    tl_d = {TL1, TL2, TL3, TL4};
  end

  always_comb begin
    cls = CL_ILL;
    if (tl_q == '0)
      cls = CL_AR;
    else if (tl1 == GREEN && tl3 == GREEN && tl2 == RED && tl4 == RED)
      cls = CL_G13;
    else if (tl2 == GREEN && tl4 == GREEN && tl1 == RED && tl3 == RED)
      cls = CL_G24;
  end

  assign same_cls   = (cls == CL_G13 && state_q == ST_G13) ||
                      (cls == CL_G24 && state_q == ST_G24) ||
                      (cls == CL_AR  && state_q == ST_AR);
  assign enters_g13 = (cls == CL_G13) && (state_q != ST_G13);
  assign enters_g24 = (cls == CL_G24) && (state_q != ST_G24);
  assign green_end  = (state_q == ST_G13 && cls != CL_G13) ||
                      (state_q == ST_G24 && cls != CL_G24);
  // Sequence rules only apply while tracking; a latched fault must not block its own clear.
  assign tracking   = (state_q != ST_FAULT);

  assign v1 = (tl1 == GREEN || tl3 == GREEN) && (tl2 == GREEN || tl4 == GREEN);
  assign v2 = (tl1 != tl3) || (tl2 != tl4);
  assign v3 = tl1[1] | tl2[1] | tl3[1] | tl4[1];
  assign v4 = tracking && (red_cnt_q < RED_MIN_L) &&
              ((enters_g13 && last_green_q == LG_24) || (enters_g24 && last_green_q == LG_13));
  assign v5 = tracking && green_end && !exempt_q && (green_cnt_q < GREEN_MIN_L);

`ifdef TLM_WATCHDOG_EN
  localparam logic [7:0] WATCHDOG_L = 8'(WATCHDOG);
  logic [7:0] stay_cnt_q, stay_cnt_d;

  assign v6 = tracking && (stay_cnt_q >= WATCHDOG_L);

  always_comb begin
    stay_cnt_d = stay_cnt_q;
    if (arm)
      stay_cnt_d = '0;
    else if (tracking && !viol)
      stay_cnt_d = same_cls ? sat_inc(stay_cnt_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stay_cnt_q <= '0;
    else     stay_cnt_q <= stay_cnt_d;
  end
`else
  logic wd_unused;
  assign wd_unused = ^WATCHDOG;
  assign v6 = 1'b0;
`endif

  always_comb begin
    code_now = 3'd0;
    if      (v1) code_now = 3'd1;
    else if (v2) code_now = 3'd2;
    else if (v3) code_now = 3'd3;
    else if (v4) code_now = 3'd4;
    else if (v5) code_now = 3'd5;
    else if (v6) code_now = 3'd6;
  end

  assign viol = (code_now != 3'd0);
  assign arm  = fault_clear && !viol;

  always_comb begin
    state_d      = state_q;
    last_green_d = last_green_q;
    red_cnt_d    = red_cnt_q;
    green_cnt_d  = green_cnt_q;
    exempt_d     = exempt_q;
    fault_code_d = fault_code_q;
    flash_d      = flash_q;
    flash_cnt_d  = flash_cnt_q;
    if (arm) begin
      state_d      = ST_UNARMED;
      last_green_d = LG_NONE;
      red_cnt_d    = '0;
      green_cnt_d  = '0;
      exempt_d     = 1'b1;
      fault_code_d = '0;
      flash_d      = 1'b0;
      flash_cnt_d  = '0;
    end else if (state_q == ST_FAULT) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_d     = ~flash_q;
        flash_cnt_d = '0;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
      end
    end else if (viol) begin
      state_d      = ST_FAULT;
      fault_code_d = code_now;
      flash_d      = 1'b1;
      flash_cnt_d  = '0;
    end else begin
      red_cnt_d   = (cls == CL_AR) ? sat_inc(red_cnt_q) : '0;
      green_cnt_d = '0;
      if (cls == CL_G13 || cls == CL_G24)
        green_cnt_d = same_cls ? sat_inc(green_cnt_q) : 8'd1;
      if (green_end)
        exempt_d = 1'b0;
      case (cls)
        CL_G13: begin
          state_d      = ST_G13;
          last_green_d = LG_13;
        end
        CL_G24: begin
          state_d      = ST_G24;
          last_green_d = LG_24;
        end
        CL_AR:   state_d = ST_AR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNARMED;
      last_green_q <= LG_NONE;
      tl_q         <= '0;
      red_cnt_q    <= '0;
      green_cnt_q  <= '0;
      flash_cnt_q  <= '0;
      exempt_q     <= 1'b1;
      fault_code_q <= '0;
      flash_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_green_q <= last_green_d;
      tl_q         <= tl_d;
      red_cnt_q    <= red_cnt_d;
      green_cnt_q  <= green_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      exempt_q     <= exempt_d;
      fault_code_q <= fault_code_d;
      flash_q      <= flash_d;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign flash      = flash_q;
  assign blank      = fault || viol;
  assign LAMP1      = blank ? RED : tl1;
  assign LAMP2      = blank ? RED : tl2;
  assign LAMP3      = blank ? RED : tl3;
  assign LAMP4      = blank ? RED : tl4;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Scoreboard bench for tl_conflict_monitor: directed lamp-bus sequences with hand-derived expected outputs.
module tb_tl_conflict_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] TL1, TL2, TL3, TL4;
  logic       fault_clear;
  logic [1:0] LAMP1, LAMP2, LAMP3, LAMP4;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;

  tl_conflict_monitor #(
    .RED_MIN    (3),
    .GREEN_MIN  (10),
    .WATCHDOG   (63),
    .FLASH_HALF (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .TL1         (TL1),
    .TL2         (TL2),
    .TL3         (TL3),
    .TL4         (TL4),
    .fault_clear (fault_clear),
    .LAMP1       (LAMP1),
    .LAMP2       (LAMP2),
    .LAMP3       (LAMP3),
    .LAMP4       (LAMP4),
    .fault       (fault),
    .fault_code  (fault_code),
    .flash       (flash)
  );

  always #5 clk = ~clk;

  // Patterns packed as {TL1,TL2,TL3,TL4}
  localparam logic [7:0] P_AR   = 8'h00;
  localparam logic [7:0] P_G13  = 8'h44;
  localparam logic [7:0] P_G24  = 8'h11;
  localparam logic [7:0] P_CONF = 8'h54;
  localparam logic [7:0] P_BAD  = 8'h80;

  typedef struct {
    logic [13:0] v;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  logic [13:0] dut_out;
  assign dut_out = {LAMP1, LAMP2, LAMP3, LAMP4, fault, fault_code, flash};

  task automatic compare(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got lamps=%h fault=%b code=%0d flash=%b, required lamps=%h fault=%b code=%0d flash=%b",
               name, act[13:6], act[5], act[4:2], act[0], exp[13:6], exp[5], exp[4:2], exp[0]);
    end
  endtask

  // Expected response for outputs observed after the next rising edge.
  task automatic step(input logic [7:0] tl, input logic clr, input logic blank,
                      input logic ef, input logic [2:0] ec, input logic efl);
    exp_t e;
    @(negedge clk);
    {TL1, TL2, TL3, TL4} = tl;
    fault_clear = clr;
    e.v  = {(blank ? 8'h00 : tl), ef, ec, efl};
    e.id = step_no;
    step_no++;
    sb.push_back(e);
  endtask

  task automatic run(input logic [7:0] tl, input int n);
    for (int i = 0; i < n; i++) step(tl, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare($sformatf("step%0d", e.id), dut_out, e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    {TL1, TL2, TL3, TL4} = P_AR;
    fault_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare("reset_state", dut_out, 14'h0);
    @(negedge clk);
    rst = 1'b0;

    // Normal phase rotation
    for (int r = 0; r < 3; r++) begin
      run(P_G13, 11);
      run(P_AR, 4);
      run(P_G24, 11);
      run(P_AR, 4);
    end

    // Conflict, then flash with 16-cycle period, then clear
    step(P_CONF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int j = 1; j <= 20; j++)
      step(P_AR, 1'b0, 1'b1, 1'b1, 3'd1, (((j - 1) / 8) % 2) == 0);
    step(P_AR, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Direct green-to-green swap
    run(P_G13, 11);
    step(P_G24, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(P_AR,  1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    step(P_AR,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Insufficient all-red clearance
    run(P_G13, 11);
    run(P_AR, 2);
    step(P_G24, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(P_AR,  1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    step(P_AR,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Short green once armed
    run(P_G13, 11);
    run(P_AR, 4);
    run(P_G24, 5);
    step(P_AR,  1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(P_BAD, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1);
    // Clear requests while the sampled bus is illegal are ignored
    step(P_BAD, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    step(P_AR,  1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    step(P_AR,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    // First green after clear is exempt from minimum green
    run(P_G13, 4);
    run(P_AR, 3);

    // Asynchronous reset while faulted
    step(P_CONF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(P_AR,   1'b0, 1'b1, 1'b1, 3'd1, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    {TL1, TL2, TL3, TL4} = P_G13;
    #1 compare("async_reset", dut_out, 14'h0);
    {TL1, TL2, TL3, TL4} = P_AR;
    @(negedge clk);
    rst = 1'b0;
    run(P_G13, 3);
    run(P_AR, 2);

    // Long hold of one phase
    for (int j = 1; j <= 70; j++) begin
`ifdef TLM_WATCHDOG_EN
      if (j < 65)       step(P_G13, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      else if (j == 65) step(P_G13, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      else              step(P_G13, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
`else
      step(P_G13, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
`endif
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
